// File: rtl/mul_share_arbiter.sv
// Round-robin sequencer that time-shares one shift-add multiplier among NUM_REQ
// requesters, returning tagged products and converting a hung multiply into an error.
module mul_share_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    parameter  int TIMEOUT = 64,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_product,
    input  logic                     mul_done,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     rsp_err
);

    localparam int CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   scan_idx;
    logic [IDW-1:0]   id_q;
    logic             grant_found;
    logic             accept;
    logic             complete;
    logic             timeout;
    logic             done_q;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        return (v == IDW'(NUM_REQ - 1)) ? '0 : v + IDW'(1);
    endfunction

    // First valid requester at or after rr_ptr, scanning with wrap-around.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        scan_idx    = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant       = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = (state == IDLE) && grant_found && !rst;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (grant == IDW'(i));
        end
    end

    // Only a fresh rising edge of done counts, so a level left over from the
    // previous operation cannot complete the current one.
    assign complete = (state == BUSY) && mul_done && !done_q;
    assign timeout  = (state == BUSY) && !complete && (cnt == CNTW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                if (complete || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            done_q      <= 1'b0;
            cnt         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            id_q        <= '0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
        end else begin
            done_q <= mul_done;

            if (accept) begin
                mul_a <= sel_a;
                mul_b <= sel_b;
                id_q  <= grant;
            end

            if (state == ISSUE) begin
                cnt <= '0;
            end else if ((state == BUSY) && !complete && !timeout) begin
                cnt <= cnt + CNTW'(1);
            end

            if (complete) begin
                rsp_product <= mul_product;
                rsp_err     <= 1'b0;
            end else if (timeout) begin
                rsp_product <= '0;
                rsp_err     <= 1'b1;
            end

            if ((state == RESP) && rsp_ready) begin
                rr_ptr <= wrap_inc(id_q);
            end
        end
    end

    assign rsp_id = id_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: a latency-programmable multiplier model
// plus a round-robin reference model that predicts grants, products and timing.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [3:0]    req_ready;
    logic [127:0]  req_a = '0;
    logic [127:0]  req_b = '0;
    logic          mul_start;
    logic [31:0]   mul_a;
    logic [31:0]   mul_b;
    logic [63:0]   mul_product = '0;
    logic          mul_done = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [63:0]   rsp_product;
    logic          rsp_err;

    int checks  = 0;
    int errors  = 0;
    int ref_ptr = 0;
    logic [31:0] ref_a [4];
    logic [31:0] ref_b [4];

    int          lat_m   = 33;
    bit          stale_m = 1'b0;
    bit          hang_m  = 1'b0;
    int          cd_m    = 0;
    bit          busy_m  = 1'b0;
    logic [63:0] prod_m  = '0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_done(mul_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_err(rsp_err)
    );

    // Multiplier model: done rises lat_m cycles after the start cycle; it ignores reset.
    always @(posedge clk) begin
        if (mul_start) begin
            busy_m <= 1'b1;
            cd_m   <= lat_m - 1;
            prod_m <= 64'(mul_a) * 64'(mul_b);
            if (!stale_m) mul_done <= 1'b0;
        end else if (busy_m) begin
            mul_done <= 1'b0;
            if (cd_m <= 1) begin
                busy_m <= 1'b0;
                if (!hang_m) begin
                    mul_done    <= 1'b1;
                    mul_product <= prod_m;
                end
            end else begin
                cd_m <= cd_m - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    function automatic int rr_pick(input logic [3:0] m, input int p);
        int k;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (p + i) % NUM_REQ;
            if (m[k[1:0]]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int g);
        return (g < 0) ? 4'b0 : 4'(1 << g);
    endfunction

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        ref_a[id] = a;
        ref_b[id] = b;
    endtask

    task automatic wait_rsp(input int limit, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            if (rsp_valid) seen = 1'b1;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b, output bit ok);
        int n;
        bit seen;
        logic r;
        lat_m = $urandom_range(3, 40); stale_m = 1'b0; hang_m = 1'b0;
        set_req(id, a, b);
        req_valid = onehot(id);
        #1;
        r = req_ready[id];
        @(negedge clk);
        req_valid = '0;
        wait_rsp(TIMEOUT + 20, n, seen);
        handshake();
        ref_ptr = (id + 1) % NUM_REQ;
        ok = r && seen;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'($urandom);
        rsp_ready = 1'($urandom);
        req_a = {4{$urandom}};
        req_b = {4{$urandom}};
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 4'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_mul_start: got %b expected 0", mul_start); end
        checks++; if (mul_a !== '0 || mul_b !== '0) begin errors++; $display("[TB] FAIL reset_mul_ab: got %0h/%0h expected 0/0", mul_a, mul_b); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0 || rsp_product !== '0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_fields: got id %0d prod %0h err %b expected 0", rsp_id, rsp_product, rsp_err); end
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b0; ref_ptr = 0;
    endtask

    task automatic test_single();
        int n;
        bit seen;
        lat_m = 33; stale_m = 1'b0; hang_m = 1'b0;
        set_req(2, 32'd13, 32'd11);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (mul_start !== 1'b1) begin errors++; $display("[TB] FAIL single_start: got %b expected 1", mul_start); end
        checks++; if (mul_a !== 32'd13 || mul_b !== 32'd11) begin errors++; $display("[TB] FAIL single_operands: got %0d/%0d expected 13/11", mul_a, mul_b); end
        wait_rsp(TIMEOUT + 20, n, seen);
        checks++; if (!seen || n + 1 != 35) begin errors++; $display("[TB] FAIL single_latency: got %0d (seen %b) expected 35", n + 1, seen); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("[TB] FAIL single_id: got %0d expected 2", rsp_id); end
        checks++; if (rsp_product !== 64'd143) begin errors++; $display("[TB] FAIL single_product: got %0d expected 143", rsp_product); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL single_err: got %b expected 0", rsp_err); end
        handshake();
        ref_ptr = 3;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_drop: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int n, g, w;
        bit seen;
        logic [63:0] expp;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; ref_ptr = 0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(2 * i + 1), 32'(2 * i + 2));
        req_valid = 4'b1111;
        for (int op = 0; op < 5; op++) begin
            lat_m = $urandom_range(3, 40);
            #1;
            w = 0;
            while (req_ready == 4'b0 && w < 8) begin @(negedge clk); #1; w++; end
            g = rr_pick(4'b1111, ref_ptr);
            checks++; if (req_ready !== onehot(g)) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", op, req_ready, onehot(g)); end
            @(negedge clk);
            wait_rsp(TIMEOUT + 20, n, seen);
            expp = 64'(ref_a[g]) * 64'(ref_b[g]);
            checks++; if (!seen || rsp_id !== 2'(g)) begin errors++; $display("[TB] FAIL rr_id%0d: got %0d (seen %b) expected %0d", op, rsp_id, seen, g); end
            checks++; if (rsp_product !== expp || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rr_product%0d: got %0d err %b expected %0d", op, rsp_product, rsp_err, expp); end
            handshake();
            ref_ptr = (g + 1) % NUM_REQ;
        end
        req_valid = '0;
    endtask

    task automatic test_back_pressure();
        int n, id, other;
        bit seen;
        logic [63:0] expp;
        id = $urandom_range(0, 3);
        other = (id + 1) % NUM_REQ;
        lat_m = $urandom_range(3, 40); stale_m = 1'b0; hang_m = 1'b0;
        set_req(id, $urandom, $urandom);
        req_valid = onehot(id);
        @(negedge clk);
        set_req(other, $urandom, $urandom);
        req_valid = onehot(other);
        wait_rsp(TIMEOUT + 20, n, seen);
        expp = 64'(ref_a[id]) * 64'(ref_b[id]);
        for (int t = 0; t < 10; t++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(id) || rsp_product !== expp || rsp_err !== 1'b0 || req_ready !== 4'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got v %b id %0d prod %0h err %b rdy %b expected v 1 id %0d prod %0h err 0 rdy 0000",
                         t, rsp_valid, rsp_id, rsp_product, rsp_err, req_ready, id, expp);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got %b expected 1", rsp_valid); end
        @(negedge clk);
        rsp_ready = 1'b0;
        ref_ptr = (id + 1) % NUM_REQ;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_done: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_watchdog();
        int n, id, lat;
        bit seen;
        logic [63:0] expp;
        hang_m = 1'b1; stale_m = 1'b0;
        id = $urandom_range(0, 3);
        set_req(id, $urandom, $urandom);
        req_valid = onehot(id);
        #1;
        checks++; if (req_ready !== onehot(id)) begin errors++; $display("[TB] FAIL wd_ready: got %b expected %b", req_ready, onehot(id)); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(TIMEOUT + 20, n, seen);
        checks++; if (!seen || n + 1 != TIMEOUT + 2) begin errors++; $display("[TB] FAIL wd_latency: got %0d (seen %b) expected %0d", n + 1, seen, TIMEOUT + 2); end
        checks++; if (rsp_err !== 1'b1 || rsp_product !== '0 || rsp_id !== 2'(id)) begin errors++; $display("[TB] FAIL wd_fields: got err %b prod %0h id %0d expected 1 0 %0d", rsp_err, rsp_product, rsp_id, id); end
        handshake();
        ref_ptr = (id + 1) % NUM_REQ;
        hang_m = 1'b0;
        id = $urandom_range(0, 3);
        lat = $urandom_range(3, 40);
        lat_m = lat;
        set_req(id, $urandom, $urandom);
        req_valid = onehot(id);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(TIMEOUT + 20, n, seen);
        expp = 64'(ref_a[id]) * 64'(ref_b[id]);
        checks++; if (!seen || n + 1 != lat + 2) begin errors++; $display("[TB] FAIL wd_recover_latency: got %0d expected %0d", n + 1, lat + 2); end
        checks++; if (rsp_err !== 1'b0 || rsp_product !== expp) begin errors++; $display("[TB] FAIL wd_recover_fields: got err %b prod %0h expected 0 %0h", rsp_err, rsp_product, expp); end
        handshake();
        ref_ptr = (id + 1) % NUM_REQ;
    endtask

    task automatic test_stale();
        int n, id;
        bit seen, ok;
        run_op($urandom_range(0, 3), $urandom, $urandom, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL stale_prep: got ok %b expected 1", ok); end
        stale_m = 1'b1; lat_m = 33;
        id = $urandom_range(0, 3);
        set_req(id, 32'd15, 32'd15);
        req_valid = onehot(id);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(TIMEOUT + 20, n, seen);
        checks++; if (!seen || n + 1 != 35) begin errors++; $display("[TB] FAIL stale_latency: got %0d (seen %b) expected 35", n + 1, seen); end
        checks++; if (rsp_product !== 64'd225 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL stale_product: got %0d err %b expected 225 0", rsp_product, rsp_err); end
        handshake();
        ref_ptr = (id + 1) % NUM_REQ;
        stale_m = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n, late, g;
        bit seen, ok;
        logic [63:0] expp;
        run_op(1, $urandom, $urandom, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_prep: got ok %b expected 1", ok); end
        lat_m = 33;
        set_req(2, $urandom, $urandom);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0 || mul_start !== 1'b0 || mul_a !== '0 || mul_b !== '0 ||
            rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_product !== '0 || rsp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmid_outputs: got rdy %b st %b a %0h b %0h v %b id %0d p %0h e %b expected all 0",
                     req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, rsp_err);
        end
        rst = 1'b0;
        ref_ptr = 0;
        late = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) late++;
        end
        checks++; if (late != 0) begin errors++; $display("[TB] FAIL rmid_late_done: got %0d response cycles expected 0", late); end
        for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom, $urandom);
        lat_m = $urandom_range(3, 40);
        req_valid = 4'b1111;
        #1;
        g = rr_pick(4'b1111, ref_ptr);
        checks++; if (req_ready !== onehot(g)) begin errors++; $display("[TB] FAIL rmid_grant: got %b expected %b", req_ready, onehot(g)); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(TIMEOUT + 20, n, seen);
        expp = 64'(ref_a[g]) * 64'(ref_b[g]);
        checks++; if (!seen || rsp_id !== 2'(g) || rsp_product !== expp) begin errors++; $display("[TB] FAIL rmid_rsp: got id %0d prod %0h expected %0d %0h", rsp_id, rsp_product, g, expp); end
        handshake();
        ref_ptr = (g + 1) % NUM_REQ;
    endtask

    task automatic test_random();
        logic [3:0]  pend;
        logic [63:0] expp;
        int g, n, lat;
        bit seen;
        pend = '0; stale_m = 1'b0; hang_m = 1'b0;
        for (int op = 0; op < 20; op++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    set_req(i, $urandom, $urandom);
                end
            end
            if (pend == 4'b0) begin
                pend[0] = 1'b1;
                set_req(0, $urandom, $urandom);
            end
            lat = $urandom_range(3, 40);
            lat_m = lat;
            req_valid = pend;
            #1;
            g = rr_pick(pend, ref_ptr);
            checks++; if (req_ready !== onehot(g)) begin errors++; $display("[TB] FAIL rand_grant%0d: got %b expected %b", op, req_ready, onehot(g)); end
            @(negedge clk);
            pend[g[1:0]] = 1'b0;
            req_valid = pend;
            checks++;
            if (mul_start !== 1'b1 || mul_a !== ref_a[g] || mul_b !== ref_b[g]) begin
                errors++;
                $display("[TB] FAIL rand_issue%0d: got st %b a %0h b %0h expected 1 %0h %0h", op, mul_start, mul_a, mul_b, ref_a[g], ref_b[g]);
            end
            wait_rsp(TIMEOUT + 20, n, seen);
            expp = 64'(ref_a[g]) * 64'(ref_b[g]);
            checks++; if (!seen || n + 1 != lat + 2) begin errors++; $display("[TB] FAIL rand_latency%0d: got %0d expected %0d", op, n + 1, lat + 2); end
            checks++;
            if (rsp_id !== 2'(g) || rsp_product !== expp || rsp_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rand_rsp%0d: got id %0d prod %0h err %b expected %0d %0h 0", op, rsp_id, rsp_product, rsp_err, g, expp);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
            ref_ptr = (g + 1) % NUM_REQ;
        end
        req_valid = '0;
    endtask

    initial begin
        $display("[TB] starting mul_share_arbiter bench");
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_watchdog();
        test_stale();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one `shift_add_multiplier` instance among `NUM_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake, then drives the multiplier's `start`/`A`/`B`. It detects completion on `done` and returns the product with the requester ID on a single valid/ready response port. A cycle-count watchdog converts a hung multiply into an error response.

## Interface

- `NUM_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 32, operand width; product is `2*WIDTH`
- `TIMEOUT`, 64, maximum BUSY cycles before error response (must exceed multiplier latency, nominally 33)
- `IDW`, `max(1,$clog2(NUM_REQ))`, ID width (localparam)

Ports:

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  one-hot accept strobe
- `req_a`  in  NUM_REQ*WIDTH  packed operand A, requester i at `[i*WIDTH +: WIDTH]`
- `req_b`  in  NUM_REQ*WIDTH  packed operand B, same packing
- `mul_start`  out  1  one-cycle start pulse to multiplier
- `mul_a`, `mul_b`  out  WIDTH  operands to multiplier, registered
- `mul_product`  in  2*WIDTH  multiplier result
- `mul_done`  in  1  multiplier done level
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  IDW  index of the requester that owns the response
- `rsp_product`  out  2*WIDTH  product (0 on error)
- `rsp_err`  out  1  1 = watchdog timeout

## Operation

- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - Grant goes to the first asserted `req_valid` at or after pointer `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[grant]`=1 combinationally in the same cycle, so the handshake completes that cycle.
  - On the next edge, `req_a`/`req_b` slices are captured into `mul_a`/`mul_b`, the grant ID is latched, and the FSM moves to ISSUE.
  - With no valid request, the FSM stays in IDLE.
- ISSUE: `mul_start`=1 for exactly this cycle. Clear the watchdog counter. Go to BUSY.
- BUSY:
  - `done_q` is a register tracking `mul_done` every cycle in all states.
  - Completion is `mul_done & ~done_q` (rising edge). On completion, capture `mul_product` into `rsp_product`, set `rsp_err`=0, and go to RESP.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 with no completion, set `rsp_product`=0, `rsp_err`=1, and go to RESP.
  - If completion and timeout occur in the same cycle, completion wins and `rsp_err`=0.
- RESP:
  - `rsp_valid`=1. `rsp_id`, `rsp_product` and `rsp_err` stay stable until `rsp_valid && rsp_ready`.
  - On that handshake: `rr_ptr` ← (latched ID + 1) mod NUM_REQ, and the FSM goes to IDLE.
- `mul_a`/`mul_b` hold their values from capture until the next capture.
- `req_ready` is 0 in all states except IDLE.
- Multiplier contract: `mul_done` must deassert within 2 cycles after `mul_start`. The rising-edge detect then rejects a stale done left high from the previous operation.
- Reset (any state, including mid-multiply):
  - FSM → IDLE; `rr_ptr`, `done_q` and the counter → 0.
  - All outputs → 0: `req_ready`, `mul_start`, `mul_a`, `mul_b`, `rsp_valid`, `rsp_id`, `rsp_product`, `rsp_err`.
  - An in-flight multiply is abandoned and its later `done` is ignored, because the FSM is not in BUSY.

## Timing

- Cycle 0: request accepted (`req_ready` high).
- Cycle 1: `mul_start` high, with `mul_a`/`mul_b` already valid.
- Cycle 2 onward: BUSY.
- If the `mul_done` rising edge is sampled in cycle k, `rsp_valid` rises in cycle k+1.
- With a multiplier done edge at start+33, accept-to-`rsp_valid` = 35 cycles.
- Earliest next accept is the cycle after the response handshake. Throughput is one operation per L+3 cycles at minimum (multiplier latency L).
- A timeout response appears TIMEOUT+2 cycles after accept.
- `rsp_valid` may stay high indefinitely under back-pressure. New requests are not accepted meanwhile.

## Test plan

- **Single request.** Requester 2 sends A=13, B=11 with a 33-cycle multiplier model. Required: `req_ready`=0100 at cycle 0, `mul_start` at cycle 1 with `mul_a`=13, `mul_b`=11, then `rsp_valid` with `rsp_id`=2, `rsp_product`=143, `rsp_err`=0.
- **Round-robin fairness.** All four requesters hold `req_valid` continuously with distinct operands (1×2, 3×4, 5×6, 7×8). Required: grant order 0,1,2,3,0; products 2, 12, 30, 56 tagged with matching IDs.
- **Back-pressure.** Hold `rsp_ready`=0 for 10 cycles after `rsp_valid`. Required: response fields stable throughout, `req_ready` stays 0, completion on the first cycle `rsp_ready`=1.
- **Watchdog.** Multiplier model never raises `done`, TIMEOUT=64. Required: `rsp_err`=1 and `rsp_product`=0 exactly 66 cycles after accept. The next request then completes normally.
- **Stale done.** Model holds `done` high from the previous operation and drops it 1 cycle after `mul_start`. Required: no early response; the response follows the new rising edge with the new product (15×15=225).
- **Reset mid-multiply.** Assert `rst` 10 cycles into BUSY. Required: every output reads 0 the next cycle, the late `done` produces no response, and `rr_ptr`=0, so requester 0 is granted first afterward.
